fetch_if_stage: RTL and testbench

Instruction fetch stage plus instruction buffer feeding the decode stage. It holds the PC and issues word requests to instruction memory, with at most one request outstanding. Responses are queued in a small FIFO. For each head entry it presents the instruction, its PC, the 7-bit opcode and the 12-bit raw immediate that decode sign-extends. Branch/jump redirects from execute flush the buffer and discard any in-flight response.

---
 rtl/fetch_if_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_if_stage.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_if_stage.sv
// Instruction fetch stage: PC register, single-outstanding imem requester and a
// small in-order instruction buffer presenting {pc, instr, opcode, raw imm} to decode.
module fetch_if_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int unsigned BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [6:0]  id_opcode,
    output logic [11:0] id_imm
);

    localparam int unsigned      PTR_W   = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned      CNT_W   = PTR_W + 1;
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(BUF_DEPTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        S_FETCH,
        S_WAIT,
        S_DRAIN
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [31:0]      req_pc_q, req_pc_d;
    logic [31:0]      buf_instr_q [BUF_DEPTH];
    logic [31:0]      buf_pc_q    [BUF_DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      id_instr_q, id_instr_d;
    logic [31:0]      id_pc_q, id_pc_d;

    logic             push;
    logic             pop;
    logic             space;
    logic             issue;
    logic             head_from_push;
    logic [CNT_W:0]   occ_after;

    // Occupancy seen by a new request: buffered entries after this cycle's pop,
    // plus the response landing this cycle (which frees the outstanding slot).
    always_comb begin
        push      = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;
        pop       = (count_q != '0) && id_ready;
        occ_after = {1'b0, count_q} - {{CNT_W{1'b0}}, pop} + {{CNT_W{1'b0}}, push};
        space     = occ_after < DEPTH_C;
        issue     = !rst && !redirect_valid && space &&
                    ((state_q == S_FETCH) || ((state_q == S_WAIT) && imem_rvalid));
    end

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign id_valid  = (count_q != '0);
    assign id_instr  = id_instr_q;
    assign id_pc     = id_pc_q;
    assign id_opcode = id_instr_q[6:0];

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        req_pc_d       = req_pc_q;
        rd_ptr_d       = rd_ptr_q;
        wr_ptr_d       = wr_ptr_q;
        count_d        = count_q;
        id_instr_d     = id_instr_q;
        id_pc_d        = id_pc_q;
        head_from_push = 1'b0;

        if (issue) begin
            pc_d     = pc_q + 32'd4;
            req_pc_d = pc_q;
        end

        unique case (state_q)
            S_FETCH: begin
                if (issue) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)   state_d = imem_rvalid ? S_FETCH : S_DRAIN;
                else if (imem_rvalid) state_d = issue ? S_WAIT : S_FETCH;
            end
            S_DRAIN: begin
                if (imem_rvalid) state_d = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        if (redirect_valid) begin
            pc_d     = redirect_pc & ~32'h3;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = occ_after[CNT_W-1:0];
            // The new head is the word arriving now when the buffer drains to empty
            // in this same cycle; otherwise it is already stored at the next read slot.
            head_from_push = push && ((count_q == '0) || (pop && (count_q == CNT_W'(1))));
            if (head_from_push) begin
                id_instr_d = imem_rdata;
                id_pc_d    = req_pc_q;
            end else if (count_d != '0) begin
                id_instr_d = buf_instr_q[rd_ptr_d];
                id_pc_d    = buf_pc_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH;
            pc_q       <= RESET_PC;
            req_pc_q   <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                buf_instr_q[i] <= '0;
                buf_pc_q[i]    <= '0;
            end
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            if (push) begin
                buf_instr_q[wr_ptr_q] <= imem_rdata;
                buf_pc_q[wr_ptr_q]    <= req_pc_q;
            end
        end
    end

    always_comb begin
        id_imm = '0;
        case (id_opcode)
            OP_LOAD, OP_IMM, OP_JALR: id_imm = id_instr_q[31:20];
            OP_STORE:  id_imm = {id_instr_q[31:25], id_instr_q[11:7]};
            OP_BRANCH: id_imm = {id_instr_q[31], id_instr_q[7], id_instr_q[30:25], id_instr_q[11:8]};
            default:   id_imm = '0;
        endcase
    end

endmodule

// File: tb/tb_fetch_if_stage.sv
// Scoreboard bench for fetch_if_stage: a latency-programmable imem model, directed
// phases pushing hand-computed expected decode entries, and a decoupled monitor.
module tb_fetch_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_valid;
    logic        id_ready = 1'b1;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [6:0]  id_opcode;
    logic [11:0] id_imm;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [6:0]  opc;
        logic [11:0] imm;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } req_t;

    exp_t        exp_q[$];
    req_t        pend[$];
    int unsigned ecnt = 0;
    int unsigned lat = 1;
    int unsigned seg_xfers = 0;
    int          checks = 0;
    int          failures = 0;
    bit          found;

    fetch_if_stage #(
        .RESET_PC (32'h0000_0000),
        .BUF_DEPTH(2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .id_valid      (id_valid),
        .id_ready      (id_ready),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_opcode     (id_opcode),
        .id_imm        (id_imm)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'hFFF00093;
            32'h0000_0004: return 32'h0020A423;
            32'h0000_0008: return 32'hFE000EE3;
            32'h0000_000C: return 32'h002081B3;
            32'h0000_0100: return 32'h00412083;
            32'h0000_0104: return 32'h008000E7;
            32'h0000_0200: return 32'h80000013;
            default:       return {a[19:0], 12'h037};
        endcase
    endfunction

    // Opcode and raw immediate worked out by hand for each program word.
    function automatic exp_t exp_for(input logic [31:0] a);
        exp_t e;
        e.pc    = a;
        e.instr = mem_word(a);
        case (a)
            32'h0000_0000: begin e.opc = 7'b0010011; e.imm = 12'hFFF; end
            32'h0000_0004: begin e.opc = 7'b0100011; e.imm = 12'h008; end
            32'h0000_0008: begin e.opc = 7'b1100011; e.imm = 12'hFFE; end
            32'h0000_000C: begin e.opc = 7'b0110011; e.imm = 12'h000; end
            32'h0000_0100: begin e.opc = 7'b0000011; e.imm = 12'h004; end
            32'h0000_0104: begin e.opc = 7'b1100111; e.imm = 12'h008; end
            32'h0000_0200: begin e.opc = 7'b0010011; e.imm = 12'h800; end
            default:       begin e.opc = 7'b0110111; e.imm = 12'h000; end
        endcase
        return e;
    endfunction

    task automatic check(input string nm, input logic [95:0] act, input logic [95:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic new_segment(input logic [31:0] base);
        exp_q.delete();
        seg_xfers = 0;
        for (int i = 0; i < 16; i++) exp_q.push_back(exp_for(base + 32'(4 * i)));
    endtask

    task automatic wait_xfers(input int unsigned n, input int unsigned budget);
        int unsigned k = 0;
        while (seg_xfers < n && k < budget) begin
            @(posedge clk);
            k++;
        end
        checks++;
        if (seg_xfers < n) begin
            failures++;
            $display("FAIL xfer_budget: got %0d transfers required %0d", seg_xfers, n);
        end
    endtask

    // Instruction memory: accepts every request, answers in order after lat cycles.
    always begin
        @(posedge clk);
        ecnt++;
        #1;
        if (rst) begin
            pend.delete();
            imem_rvalid = 1'b0;
        end else if (pend.size() > 0 && pend[0].due == ecnt + 1) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(pend[0].addr);
            void'(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
        end
        @(negedge clk);
        if (rst) pend.delete();
        else if (imem_req) pend.push_back('{addr: imem_addr, due: ecnt + 1 + lat});
    end

    // Monitor: every accepted decode transfer must match the next expected entry.
    always @(negedge clk) begin
        if (!rst && id_valid && id_ready) begin
            seg_xfers++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL xfer_unexpected: got pc %h required no transfer", id_pc);
            end else begin
                check("xfer", {id_pc, id_instr, id_opcode, id_imm}, exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        // Reset state, first fetch latency, back-to-back issue and immediate decode.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_imem_req", imem_req, 1'b0);
        check("rst_imem_addr", imem_addr, 32'h0);
        check("rst_id_valid", id_valid, 1'b0);
        check("rst_id_instr", id_instr, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        tick();
        rst = 1'b0;
        new_segment(32'h0);
        @(negedge clk);
        check("t0_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        @(negedge clk);
        check("t1_req", {imem_req, imem_addr}, {1'b1, 32'h4});
        check("t1_id_valid", id_valid, 1'b0);
        @(negedge clk);
        check("t2_req", {imem_req, imem_addr}, {1'b1, 32'h8});
        check("t2_id_head", {id_valid, id_pc}, {1'b1, 32'h0});
        wait_xfers(6, 40);

        // Backpressure: buffer fills to depth, fetching stops, head holds.
        tick();
        rst = 1'b1;
        id_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        new_segment(32'h0);
        @(negedge clk);
        check("bp_t0_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        @(negedge clk);
        check("bp_t1_req", {imem_req, imem_addr}, {1'b1, 32'h4});
        @(negedge clk);
        check("bp_t2_req", imem_req, 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_hold_req", imem_req, 1'b0);
            check("bp_hold_addr", imem_addr, 32'h8);
            check("bp_hold_head", {id_valid, id_pc, id_instr}, {1'b1, 32'h0, 32'hFFF00093});
        end
        tick();
        id_ready = 1'b1;
        wait_xfers(4, 40);

        // Redirect while a latency-3 request to 0x8 is outstanding.
        tick();
        rst = 1'b1;
        lat = 3;
        tick();
        rst = 1'b0;
        new_segment(32'h0);
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (imem_req && imem_addr == 32'h8) found = 1'b1;
        end
        check("req_to_8_seen", found, 1'b1);
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h100;
        @(negedge clk);
        check("redir_cycle_req", imem_req, 1'b0);
        tick();
        redirect_valid = 1'b0;
        new_segment(32'h100);
        @(negedge clk);
        check("drain_req", {imem_req, imem_addr, id_valid}, {1'b0, 32'h100, 1'b0});
        @(negedge clk);
        check("drain_rvalid_req", imem_req, 1'b0);
        @(negedge clk);
        check("post_drain_req", {imem_req, imem_addr}, {1'b1, 32'h100});
        wait_xfers(2, 40);

        // Redirect coinciding with a response while the buffer holds an entry.
        tick();
        rst = 1'b1;
        lat = 2;
        id_ready = 1'b0;
        tick();
        rst = 1'b0;
        new_segment(32'h0);
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h203;
        @(negedge clk);
        check("redir_rv_req", imem_req, 1'b0);
        check("redir_rv_pre_valid", id_valid, 1'b1);
        tick();
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        new_segment(32'h200);
        @(negedge clk);
        check("redir_rv_flushed", id_valid, 1'b0);
        check("redir_rv_next_req", {imem_req, imem_addr}, {1'b1, 32'h200});
        wait_xfers(2, 40);

        // Reset asserted while waiting with an entry buffered.
        tick();
        rst = 1'b1;
        id_ready = 1'b0;
        tick();
        rst = 1'b0;
        new_segment(32'h0);
        repeat (3) tick();
        check("pre_rst_valid", id_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("mid_rst_outputs", {id_valid, imem_req, id_pc, id_instr}, {1'b0, 1'b0, 32'h0, 32'h0});
        @(negedge clk);
        check("mid_rst_req", {imem_req, imem_addr}, {1'b0, 32'h0});
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        id_ready = 1'b1;
        new_segment(32'h0);
        @(negedge clk);
        check("restart_req", {imem_req, imem_addr}, {1'b1, 32'h0});
        wait_xfers(3, 40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
